bus_arbiter_split: RTL and testbench

Central bus arbiter/scheduler for the serial system bus: it shares the bus between two master ports (fixed priority, M1 > M2) and receives the serially shifted slave select from the granted master. It drives the master and slave mux selects and supports split transactions from one split-capable slave. A watchdog releases a bus held too long. It sits at top level beside the address/data/response muxes it steers.

---
 rtl/bus_arbiter_split.sv | 208 ++++++++++++++++++++
 tb/tb_bus_arbiter_split.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_split.sv
// Serial-bus arbiter: fixed-priority grant (M1 > M2), serial slave select,
// split transactions from one slave, and a watchdog on long bus tenures.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   m1_request, m2_request        master approval requests
//   m1_slave_sel, m2_slave_sel    serial slave select, MSB first
//   m1_trans_done, m2_trans_done  transaction-complete pulses
//   split_en                      split request/hold from SPLIT_SLAVE
//   m1_grant, m2_grant            approval grants (never both high)
//   arbitor_busy                  arbiter not idle
//   bus_busy                      data phase in progress
//   master_sel                    bus mux select: 0=M1, 1=M2
//   slave_sel                     decoded slave index
//   split_active                  a split transaction is parked
//   timeout                       one-cycle pulse on watchdog release
module bus_arbiter_split #(
    parameter int SLAVE_LEN      = 2,
    parameter int SPLIT_SLAVE    = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic                 m1_slave_sel,
    input  logic                 m2_slave_sel,
    input  logic                 m1_trans_done,
    input  logic                 m2_trans_done,
    input  logic                 split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbitor_busy,
    output logic                 bus_busy,
    output logic                 master_sel,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 split_active,
    output logic                 timeout
);

    typedef enum logic [1:0] {IDLE, SELECT, BUSY, RELEASE} state_t;

    localparam int                   CW        = $clog2(SLAVE_LEN + 1);
    localparam logic [CW-1:0]        SEL_LAST  = CW'(SLAVE_LEN);
    localparam logic [SLAVE_LEN-1:0] SPLIT_IDX = SLAVE_LEN'(SPLIT_SLAVE);
    localparam logic [11:0]          WD_LAST   = 12'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 m1_grant_q, m1_grant_d;
    logic                 m2_grant_q, m2_grant_d;
    logic                 bus_busy_q, bus_busy_d;
    logic                 master_sel_q, master_sel_d;
    logic [SLAVE_LEN-1:0] slave_sel_q, slave_sel_d;
    logic                 split_active_q, split_active_d;
    logic                 split_master_q, split_master_d;
    logic                 timeout_q, timeout_d;
    logic                 split_en_q, split_en_d;
    logic [11:0]          wd_q, wd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SLAVE_LEN-1:0] shift_q, shift_d;

    logic                 split_rise;
    logic                 resume;
    logic                 m1_ok;
    logic                 m2_ok;
    logic                 sel_bit;
    logic                 done;
    logic [SLAVE_LEN-1:0] shift_nxt;

    assign split_rise = split_en & ~split_en_q;
    assign resume     = split_active_q & ~split_en;
    // A parked master may not open a second transaction until resumed.
    assign m1_ok      = m1_request & ~(split_active_q & ~split_master_q);
    assign m2_ok      = m2_request & ~(split_active_q & split_master_q);
    assign sel_bit    = master_sel_q ? m2_slave_sel : m1_slave_sel;
    assign done       = master_sel_q ? m2_trans_done : m1_trans_done;
    assign shift_nxt  = (shift_q << 1) | SLAVE_LEN'(sel_bit);

    always_comb begin
        state_d        = state_q;
        m1_grant_d     = m1_grant_q;
        m2_grant_d     = m2_grant_q;
        bus_busy_d     = bus_busy_q;
        master_sel_d   = master_sel_q;
        slave_sel_d    = slave_sel_q;
        split_active_d = split_active_q;
        split_master_d = split_master_q;
        timeout_d      = 1'b0;
        split_en_d     = split_en;
        wd_d           = wd_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                // Grants are already low in RELEASE; arbitrating here gives
                // the two-cycle trans_done-to-next-grant turnaround.
                m1_grant_d = 1'b0;
                m2_grant_d = 1'b0;
                bus_busy_d = 1'b0;
                state_d    = IDLE;
                if (resume) begin
                    m1_grant_d     = ~split_master_q;
                    m2_grant_d     = split_master_q;
                    master_sel_d   = split_master_q;
                    slave_sel_d    = SPLIT_IDX;
                    split_active_d = 1'b0;
                    bus_busy_d     = 1'b1;
                    wd_d           = '0;
                    state_d        = BUSY;
                end else if (m1_ok) begin
                    m1_grant_d   = 1'b1;
                    master_sel_d = 1'b0;
                    cnt_d        = '0;
                    shift_d      = '0;
                    state_d      = SELECT;
                end else if (m2_ok) begin
                    m2_grant_d   = 1'b1;
                    master_sel_d = 1'b1;
                    cnt_d        = '0;
                    shift_d      = '0;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                // First SELECT cycle is the master's turnaround after seeing
                // the grant; bits are sampled on the following cycles.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q != '0) begin
                    shift_d = shift_nxt;
                end
                if (cnt_q == SEL_LAST) begin
                    slave_sel_d = shift_nxt;
                    bus_busy_d  = 1'b1;
                    wd_d        = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (wd_q != 12'hFFF) begin
                    wd_d = wd_q + 12'd1;
                end
                if (done) begin
                    m1_grant_d = 1'b0;
                    m2_grant_d = 1'b0;
                    bus_busy_d = 1'b0;
                    state_d    = RELEASE;
                end else if (wd_q >= WD_LAST) begin
                    m1_grant_d = 1'b0;
                    m2_grant_d = 1'b0;
                    bus_busy_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = RELEASE;
                end else if (split_rise && slave_sel_q == SPLIT_IDX
                             && !split_active_q) begin
                    m1_grant_d     = 1'b0;
                    m2_grant_d     = 1'b0;
                    bus_busy_d     = 1'b0;
                    split_active_d = 1'b1;
                    split_master_d = master_sel_q;
                    state_d        = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            m1_grant_q     <= 1'b0;
            m2_grant_q     <= 1'b0;
            bus_busy_q     <= 1'b0;
            master_sel_q   <= 1'b0;
            slave_sel_q    <= '0;
            split_active_q <= 1'b0;
            split_master_q <= 1'b0;
            timeout_q      <= 1'b0;
            split_en_q     <= 1'b0;
            wd_q           <= '0;
            cnt_q          <= '0;
            shift_q        <= '0;
        end else begin
            state_q        <= state_d;
            m1_grant_q     <= m1_grant_d;
            m2_grant_q     <= m2_grant_d;
            bus_busy_q     <= bus_busy_d;
            master_sel_q   <= master_sel_d;
            slave_sel_q    <= slave_sel_d;
            split_active_q <= split_active_d;
            split_master_q <= split_master_d;
            timeout_q      <= timeout_d;
            split_en_q     <= split_en_d;
            wd_q           <= wd_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
        end
    end

    assign m1_grant     = m1_grant_q;
    assign m2_grant     = m2_grant_q;
    assign bus_busy     = bus_busy_q;
    assign master_sel   = master_sel_q;
    assign slave_sel    = slave_sel_q;
    assign split_active = split_active_q;
    assign timeout      = timeout_q;
    assign arbitor_busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Bench for bus_arbiter_split: open-loop master/slave driver pushes expected
// grant/busy/release events; a negedge monitor pops and compares them.
module tb_bus_arbiter_split;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req [2];
    logic       sel [2];
    logic       dn  [2];
    logic       split_en;
    logic       m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel;
    logic [1:0] slave_sel;
    logic       split_active, timeout;

    bus_arbiter_split #(
        .SLAVE_LEN(2),
        .SPLIT_SLAVE(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m1_request(req[0]),
        .m2_request(req[1]),
        .m1_slave_sel(sel[0]),
        .m2_slave_sel(sel[1]),
        .m1_trans_done(dn[0]),
        .m2_trans_done(dn[1]),
        .split_en(split_en),
        .m1_grant(m1_grant),
        .m2_grant(m2_grant),
        .arbitor_busy(arbitor_busy),
        .bus_busy(bus_busy),
        .master_sel(master_sel),
        .slave_sel(slave_sel),
        .split_active(split_active),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // kind: 0 = grant rise, 1 = bus_busy rise, 2 = release (bus_busy fall)
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic        m;
        logic [1:0]  slv;
        logic        to;
        logic        sa;
    } ev_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic p_g1 = 0, p_g2 = 0, p_bb = 0;
    logic rel_now;
    logic fin = 0, fin_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int k, int c, int m, int s, int t, int a);
        ev_t e;
        e.kind = 2'(k);
        e.cyc  = 32'(c);
        e.m    = 1'(m);
        e.slv  = 2'(s);
        e.to   = 1'(t);
        e.sa   = 1'(a);
        return e;
    endfunction

    task automatic chk(input ev_t got);
        ev_t exp;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d cyc=%0d m=%0d slv=%0d to=%0d sa=%0d",
                     got.kind, got.cyc, got.m, got.slv, got.to, got.sa);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL event got kind=%0d cyc=%0d m=%0d slv=%0d to=%0d sa=%0d exp kind=%0d cyc=%0d m=%0d slv=%0d to=%0d sa=%0d",
                         got.kind, got.cyc, got.m, got.slv, got.to, got.sa,
                         exp.kind, exp.cyc, exp.m, exp.slv, exp.to, exp.sa);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ({m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel,
                 slave_sel, split_active, timeout} !== 9'd0) begin
                failures++;
                $display("FAIL reset_outputs got %b exp 0", {m1_grant, m2_grant,
                         arbitor_busy, bus_busy, master_sel, slave_sel,
                         split_active, timeout});
            end
            p_g1 = 0;
            p_g2 = 0;
            p_bb = 0;
        end else begin
            rel_now = p_bb && !bus_busy;
            checks++;
            if (m1_grant && m2_grant) begin
                failures++;
                $display("FAIL grant_mutex got both high exp at most one, cyc=%0d", cyc);
            end
            checks++;
            if (arbitor_busy !== (m1_grant | m2_grant | bus_busy | rel_now)) begin
                failures++;
                $display("FAIL arbitor_busy got %b exp %b cyc=%0d", arbitor_busy,
                         m1_grant | m2_grant | bus_busy | rel_now, cyc);
            end
            if (timeout && !rel_now) begin
                checks++;
                failures++;
                $display("FAIL stray_timeout got 1 exp 0 cyc=%0d", cyc);
            end
            if (rel_now) chk(mk(2, cyc, 0, 0, timeout, split_active));
            if (m1_grant && !p_g1) chk(mk(0, cyc, 0, 0, 0, 0));
            if (m2_grant && !p_g2) chk(mk(0, cyc, 1, 0, 0, 0));
            if (bus_busy && !p_bb) chk(mk(1, cyc, master_sel, slave_sel, 0, 0));
            p_g1 = m1_grant;
            p_g2 = m2_grant;
            p_bb = bus_busy;
        end
        if (fin && !fin_done) begin
            fin_done = 1;
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL pending_events got %0d left exp 0", sb.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    function automatic logic [1:0] non_split_slave();
        int t;
        t = $urandom_range(0, 2);
        return (t == 2) ? 2'd3 : 2'(t);
    endfunction

    // Master granted in cycle g shifts its slave select on g+1, g+2.
    task automatic drive_sel(input int m, input int g, input logic [1:0] slv);
        wait_to(g);
        req[m] = 0;
        wait_to(g + 1);
        sel[m] = slv[1];
        wait_to(g + 2);
        sel[m] = slv[0];
        wait_to(g + 3);
        sel[m] = 0;
    endtask

    task automatic pulse_done(input int m, input int c);
        wait_to(c);
        dn[m] = 1;
        step();
        dn[m] = 0;
    endtask

    // Normal transaction: grant g, busy g+3, done after L busy cycles.
    task automatic push_txn(input int m, input int g, input int slv, input int L,
                            input int sa);
        sb.push_back(mk(0, g, m, 0, 0, 0));
        sb.push_back(mk(1, g + 3, m, slv, 0, 0));
        sb.push_back(mk(2, g + 3 + L, 0, 0, 0, sa));
    endtask

    task automatic single(input int m, input logic [1:0] slv, input int L,
                          input bit sp);
        int g, sc;
        g = cyc + 1;
        req[m] = 1;
        push_txn(m, g, slv, L, 0);
        drive_sel(m, g, slv);
        // Split on another slave is ignored; on the split slave it coincides
        // with trans_done, which must win.
        sc = (slv == 2) ? g + 2 + L : g + 3;
        if (sp) begin
            wait_to(sc);
            split_en = 1;
        end
        pulse_done(m, g + 2 + L);
        wait_to(g + 3 + L);
        split_en = 0;
        wait_to(g + 4 + L);
    endtask

    task automatic both(input logic [1:0] sa, input int la, input logic [1:0] sb2,
                        input int lb);
        int g1, g2;
        g1 = cyc + 1;
        g2 = g1 + 3 + la + 1;
        req[0] = 1;
        req[1] = 1;
        push_txn(0, g1, sa, la, 0);
        push_txn(1, g2, sb2, lb, 0);
        drive_sel(0, g1, sa);
        pulse_done(0, g1 + 2 + la);
        drive_sel(1, g2, sb2);
        pulse_done(1, g2 + 2 + lb);
        wait_to(g2 + 4 + lb);
    endtask

    // variant 0: split_en falls after the other master finishes.
    // variant 1: split_en falls during the other master's BUSY while M1
    //            raises a new request; resume must come first.
    // variant 2: asynchronous reset during the other master's BUSY.
    task automatic split_flow(input int p, input int variant);
        int o, g, b, s, go, lo, ro, lp, f, rg, ln, gn;
        logic [1:0] so, sn;
        o  = 1 - p;
        g  = cyc + 1;
        b  = g + 3;
        s  = b + $urandom_range(0, 3);
        go = s + 2;
        so = non_split_slave();
        lo = $urandom_range(1, 7);
        ro = go + 3 + lo;
        lp = $urandom_range(1, 7);
        ln = $urandom_range(1, 7);
        sn = 2'($urandom_range(0, 3));
        f  = (variant == 1) ? go + 3 + $urandom_range(0, lo - 1)
                            : ro + $urandom_range(0, 2);
        rg = (variant == 1) ? ro + 1 : f + 1;
        gn = rg + lp + 1;
        req[p] = 1;
        sb.push_back(mk(0, g, p, 0, 0, 0));
        sb.push_back(mk(1, b, p, 2, 0, 0));
        sb.push_back(mk(2, s + 1, 0, 0, 0, 1));
        sb.push_back(mk(0, go, o, 0, 0, 0));
        sb.push_back(mk(1, go + 3, o, so, 0, 0));
        if (variant != 2) begin
            sb.push_back(mk(2, ro, 0, 0, 0, 1));
            sb.push_back(mk(0, rg, p, 0, 0, 0));
            sb.push_back(mk(1, rg, p, 2, 0, 0));
            sb.push_back(mk(2, rg + lp, 0, 0, 0, 0));
        end
        if (variant == 1) push_txn(0, gn, sn, ln, 0);
        drive_sel(p, g, 2'd2);
        wait_to(s);
        split_en = 1;
        req[o] = 1;
        drive_sel(o, go, so);
        if (variant == 2) begin
            wait_to(go + 3 + $urandom_range(0, 3));
            #2 reset = 1;
            step();
            split_en = 0;
            req[0] = 0;
            req[1] = 0;
            step();
            reset = 0;
            step();
            single(p, 2'($urandom_range(0, 3)), $urandom_range(1, 7), 0);
        end else begin
            if (variant == 1) begin
                wait_to(f);
                split_en = 0;
                req[0] = 1;
            end
            pulse_done(o, go + 2 + lo);
            wait_to(f);
            split_en = 0;
            pulse_done(p, rg + lp - 1);
            if (variant == 1) begin
                drive_sel(0, gn, sn);
                pulse_done(0, gn + 2 + ln);
                wait_to(gn + 4 + ln);
            end else begin
                wait_to(rg + lp + 1);
            end
        end
    endtask

    task automatic watchdog(input int m, input logic [1:0] slv);
        int o, g, b, r, lo;
        logic [1:0] so;
        o  = 1 - m;
        g  = cyc + 1;
        b  = g + 3;
        r  = b + TO;
        lo = $urandom_range(1, 7);
        so = 2'($urandom_range(0, 3));
        req[m] = 1;
        sb.push_back(mk(0, g, m, 0, 0, 0));
        sb.push_back(mk(1, b, m, slv, 0, 0));
        sb.push_back(mk(2, r, 0, 0, 1, 0));
        push_txn(o, r + 1, so, lo, 0);
        drive_sel(m, g, slv);
        wait_to(b + 2);
        req[o] = 1;
        drive_sel(o, r + 1, so);
        pulse_done(o, r + 3 + lo);
        wait_to(r + 5 + lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit got expired exp finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1;
        split_en = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0;
            sel[i] = 0;
            dn[i]  = 0;
        end
        step();
        step();
        step();
        reset = 0;
        step();
        single(0, 2'd2, 7, 0);
        both(2'd1, 3, 2'd0, 2);
        split_flow(0, 0);
        split_flow(0, 1);
        watchdog(0, 2'd3);
        split_flow(0, 2);
        single(1, 2'd2, 2, 1);
        single(0, 2'd1, 1, 1);
        for (int n = 0; n < 50; n++) begin
            case ($urandom_range(0, 5))
                0: single($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                          $urandom_range(1, 7), 1'($urandom_range(0, 1)));
                1: both(2'($urandom_range(0, 3)), $urandom_range(1, 7),
                        2'($urandom_range(0, 3)), $urandom_range(1, 7));
                2: split_flow($urandom_range(0, 1), 0);
                3: split_flow($urandom_range(0, 1), 1);
                4: watchdog($urandom_range(0, 1), 2'($urandom_range(0, 3)));
                default: split_flow($urandom_range(0, 1), 2);
            endcase
        end
        step();
        fin = 1;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
